decode_stage: RTL and testbench

// - ID stage of the 5-stage RV32I pipeline. Decodes the IF/ID instruction, drives register_file read addresses, decodes immediates and control, detects load-use hazards.
// - Captures everything into the ID/EX pipeline register feeding EX. Stall, flush and WB->ID bypass handled here.

---
 rtl/decode_stage.sv | 214 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ID stage of the 5-stage RV32I pipeline: decode, immediates, load-use/WB hazard stall, ID/EX register.
// Optional macro ID_WB_BYPASS_EN: forward the WB write into ex_rsN_data instead of stalling on it.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int HAZARD_EN = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [31:0]     id_instr,
    output logic [4:0]      rf_read_addr1,
    output logic [4:0]      rf_read_addr2,
    input  logic [XLEN-1:0] rf_read_data1,
    input  logic [XLEN-1:0] rf_read_data2,
    input  logic            wb_write_enable,
    input  logic [4:0]      wb_write_addr,
    input  logic [XLEN-1:0] wb_write_data,
    input  logic            ex_flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1_addr,
    output logic [4:0]      ex_rs2_addr,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic [6:0]      ex_opcode,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [6:0]      opcode;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            mem_to_reg;
        logic            branch;
        logic            jump;
        logic            illegal;
    } idex_t;

    idex_t ex_d, ex_q;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic            rs1_used, rs2_used;
    logic [XLEN-1:0] imm;
    logic            alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump, illegal;
    logic            load_use, wb_match, wb_hazard, byp1, byp2;

    assign opcode        = id_instr[6:0];
    assign rd            = id_instr[11:7];
    assign rs1           = id_instr[19:15];
    assign rs2           = id_instr[24:20];
    assign rf_read_addr1 = rs1;
    assign rf_read_addr2 = rs2;

    always_comb begin
        imm        = '0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        illegal    = 1'b0;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        case (opcode)
            OP_OP: begin
                reg_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                imm       = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
                reg_write = 1'b1; alu_src = 1'b1; rs1_used = 1'b1;
                mem_read   = (opcode == OP_LOAD);
                mem_to_reg = (opcode == OP_LOAD);
                jump       = (opcode == OP_JALR);
            end
            OP_STORE: begin
                imm       = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
                alu_src   = 1'b1; mem_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                imm    = {{(XLEN-12){id_instr[31]}}, id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
                branch = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm       = {id_instr[31:12], 12'b0};
                reg_write = 1'b1; alu_src = 1'b1;
            end
            OP_JAL: begin
                imm       = {{(XLEN-20){id_instr[31]}}, id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};
                reg_write = 1'b1; alu_src = 1'b1; jump = 1'b1;
            end
            default: begin
                illegal = 1'b1; alu_src = 1'b1;
            end
        endcase
        if (rd == 5'd0) reg_write = 1'b0;
    end

    // Hazards only count against source registers the opcode actually reads.
    assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                      ((rs1_used & (ex_q.rd == rs1)) | (rs2_used & (ex_q.rd == rs2)));
    assign wb_match = wb_write_enable & (wb_write_addr != 5'd0) &
                      ((rs1_used & (wb_write_addr == rs1)) | (rs2_used & (wb_write_addr == rs2)));

`ifdef ID_WB_BYPASS_EN
    assign wb_hazard = 1'b0;
    assign byp1 = wb_write_enable & (wb_write_addr != 5'd0) & (wb_write_addr == rs1);
    assign byp2 = wb_write_enable & (wb_write_addr != 5'd0) & (wb_write_addr == rs2);
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_write_data;
    assign wb_hazard = wb_match;
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign id_stall = (HAZARD_EN != 0) & id_valid & ~ex_flush & ~reset & (load_use | wb_hazard);

    always_comb begin
        ex_d            = '0;
        ex_d.valid      = id_valid;
        ex_d.pc         = id_pc;
        ex_d.rs1_data   = byp1 ? wb_write_data : rf_read_data1;
        ex_d.rs2_data   = byp2 ? wb_write_data : rf_read_data2;
        ex_d.imm        = imm;
        ex_d.rs1_addr   = rs1;
        ex_d.rs2_addr   = rs2;
        ex_d.rd         = rd;
        ex_d.funct3     = id_instr[14:12];
        ex_d.funct7b5   = id_instr[30];
        ex_d.opcode     = opcode;
        ex_d.alu_src    = alu_src;
        ex_d.mem_read   = mem_read;
        ex_d.mem_write  = mem_write;
        ex_d.reg_write  = reg_write;
        ex_d.mem_to_reg = mem_to_reg;
        ex_d.branch     = branch;
        ex_d.jump       = jump;
        ex_d.illegal    = illegal;
        // Flush, stall and an empty IF/ID all inject a bubble with every control bit cleared.
        if (ex_flush || id_stall || !id_valid) begin
            ex_d.valid      = 1'b0;
            ex_d.alu_src    = 1'b0;
            ex_d.mem_read   = 1'b0;
            ex_d.mem_write  = 1'b0;
            ex_d.reg_write  = 1'b0;
            ex_d.mem_to_reg = 1'b0;
            ex_d.branch     = 1'b0;
            ex_d.jump       = 1'b0;
            ex_d.illegal    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1_addr   = ex_q.rs1_addr;
    assign ex_rs2_addr   = ex_q.rs2_addr;
    assign ex_rd         = ex_q.rd;
    assign ex_funct3     = ex_q.funct3;
    assign ex_funct7b5   = ex_q.funct7b5;
    assign ex_opcode     = ex_q.opcode;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
    assign ex_illegal    = ex_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected ID/EX contents, a monitor pops on ex_valid.
module tb_decode_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc, id_instr;
    logic [4:0]  rf_read_addr1, rf_read_addr2;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic        wb_write_enable;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic        ex_flush, id_stall, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [6:0]  ex_opcode;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
    logic        ex_mem_to_reg, ex_branch, ex_jump, ex_illegal;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
        .ex_flush(ex_flush), .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_opcode(ex_opcode),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    // Register file model: xi = i*0x11 after reset, written at the clock edge, read asynchronously.
    logic [31:0] regs [32];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= i * 32'h11;
        end else if (wb_write_enable && wb_write_addr != 5'd0) begin
            regs[wb_write_addr] <= wb_write_data;
        end
    end
    assign rf_read_data1 = regs[rf_read_addr1];
    assign rf_read_data2 = regs[rf_read_addr2];

    typedef struct packed {
        logic [31:0] pc, imm, rs1d, rs2d;
        logic [4:0]  rd, rs1a, rs2a;
        logic [7:0]  ctrl; // {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, illegal}
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, imm, input logic [4:0] rd, rs1a, rs2a,
                        input logic [31:0] rs1d, rs2d, input logic [7:0] ctrl);
        exp_t e;
        e.pc = pc; e.imm = imm; e.rd = rd; e.rs1a = rs1a; e.rs2a = rs2a;
        e.rs1d = rs1d; e.rs2d = rs2d; e.ctrl = ctrl;
        q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (!reset && ex_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_issue: got ex_pc %h expected no valid instruction", ex_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("pc@%h", e.pc), ex_pc, e.pc);
                check($sformatf("imm@%h", e.pc), ex_imm, e.imm);
                check($sformatf("rd@%h", e.pc), {27'd0, ex_rd}, {27'd0, e.rd});
                check($sformatf("rs1_addr@%h", e.pc), {27'd0, ex_rs1_addr}, {27'd0, e.rs1a});
                check($sformatf("rs2_addr@%h", e.pc), {27'd0, ex_rs2_addr}, {27'd0, e.rs2a});
                check($sformatf("rs1_data@%h", e.pc), ex_rs1_data, e.rs1d);
                check($sformatf("rs2_data@%h", e.pc), ex_rs2_data, e.rs2d);
                check($sformatf("ctrl@%h", e.pc),
                      {24'd0, ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write,
                       ex_mem_to_reg, ex_branch, ex_jump, ex_illegal},
                      {24'd0, e.ctrl});
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        @(posedge clock);
        #1;
        id_valid        = v;
        id_pc           = pc;
        id_instr        = instr;
        wb_write_enable = 1'b0;
        ex_flush        = 1'b0;
    endtask

    task automatic hold();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; id_valid = 1'b0; id_pc = '0; id_instr = '0;
        wb_write_enable = 1'b0; wb_write_addr = '0; wb_write_data = '0; ex_flush = 1'b0;
        repeat (2) @(posedge clock);
        #4;
        check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset_ex_pc", ex_pc, 32'd0);
        check("reset_ex_imm", ex_imm, 32'd0);
        check("reset_ex_ctrl", {24'd0, ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write,
                                ex_mem_to_reg, ex_branch, ex_jump, ex_illegal}, 32'd0);
        check("reset_id_stall", {31'd0, id_stall}, 32'd0);
        reset = 1'b0;

        // addi x5,x0,-1
        drive(1'b1, 32'h100, 32'hFFF00293);
        push(32'h100, 32'hFFFF_FFFF, 5'd5, 5'd0, 5'd31, 32'h0, 32'h20F, 8'hC0);

        // lw x6,0(x1) followed by dependent add x7,x6,x2
        drive(1'b1, 32'h104, 32'h0000A303);
        push(32'h104, 32'h0, 5'd6, 5'd1, 5'd0, 32'h11, 32'h0, 8'hE8);
        drive(1'b1, 32'h108, 32'h002303B3);
        #3 check("load_use_stall", {31'd0, id_stall}, 32'd1);
        hold();
        #3 check("load_use_bubble", {31'd0, ex_valid}, 32'd0);
        check("load_use_release", {31'd0, id_stall}, 32'd0);
        push(32'h108, 32'h0, 5'd7, 5'd6, 5'd2, 32'h66, 32'h22, 8'h80);

        // add x4,x3,x3 while WB writes x3
        drive(1'b1, 32'h10C, 32'h00318233);
        wb_write_enable = 1'b1; wb_write_addr = 5'd3; wb_write_data = 32'hDEADBEEF;
`ifdef ID_WB_BYPASS_EN
        #3 check("wb_bypass_no_stall", {31'd0, id_stall}, 32'd0);
`else
        #3 check("wb_stall", {31'd0, id_stall}, 32'd1);
        hold();
        wb_write_enable = 1'b0;
        #3 check("wb_stall_release", {31'd0, id_stall}, 32'd0);
`endif
        push(32'h10C, 32'h0, 5'd4, 5'd3, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 8'h80);

        // Flush while a load-use hazard is present
        drive(1'b1, 32'h110, 32'h0000A303);
        push(32'h110, 32'h0, 5'd6, 5'd1, 5'd0, 32'h11, 32'h0, 8'hE8);
        drive(1'b1, 32'h114, 32'h002303B3);
        ex_flush = 1'b1;
        #3 check("flush_overrides_stall", {31'd0, id_stall}, 32'd0);
        hold();
        ex_flush = 1'b0; id_valid = 1'b0;
        #3 check("flush_kills", {31'd0, ex_valid}, 32'd0);

        drive(1'b1, 32'h118, 32'h000002FF);  // opcode 0x7F, rd=5
        push(32'h118, 32'h0, 5'd5, 5'd0, 5'd0, 32'h0, 32'h0, 8'h41);
        drive(1'b1, 32'h11C, 32'h00508013);  // addi x0,x1,5
        push(32'h11C, 32'h5, 5'd0, 5'd1, 5'd5, 32'h11, 32'h55, 8'h40);
        drive(1'b1, 32'h120, 32'h0020A423);  // sw x2,8(x1)
        push(32'h120, 32'h8, 5'd8, 5'd1, 5'd2, 32'h11, 32'h22, 8'h50);
        drive(1'b1, 32'h124, 32'hFE208EE3);  // beq x1,x2,-4
        push(32'h124, 32'hFFFF_FFFC, 5'd29, 5'd1, 5'd2, 32'h11, 32'h22, 8'h04);
        drive(1'b1, 32'h128, 32'h123454B7);  // lui x9,0x12345
        push(32'h128, 32'h1234_5000, 5'd9, 5'd8, 5'd3, 32'h88, 32'hDEADBEEF, 8'hC0);
        drive(1'b1, 32'h12C, 32'h008000EF);  // jal x1,+8
        push(32'h12C, 32'h8, 5'd1, 5'd0, 5'd8, 32'h0, 32'h88, 8'hC2);
        drive(1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clock);
        hold();
        check("scoreboard_drained", q.size(), 32'd0);
        check("idle_bubble", {31'd0, ex_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
